// File: rtl/flash_axi_pkg.sv
// Shared definitions for the flash AXI burst master.
//   state_t      : burst FSM states
//   BURST_*/SIZE_*/RESP_* : AXI4 encodings used on the EMC memory port
//   PAGE_BYTES   : AXI 4 KB boundary that a burst must not cross
//   cmd_is_bad() : alignment / 4 KB crossing check for a command
package flash_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B,
    ST_RESP
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_4B     = 3'b010;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         PAGE_BYTES  = 4096;

  // A command is rejected when the byte address is not word aligned or
  // when the burst's last byte would spill past the current 4 KB page.
  // 14 bits hold the worst case 4095 + 1024.
  function automatic logic cmd_is_bad(input logic [31:0] addr,
                                      input logic [7:0]  len);
    logic [13:0] end_off;
    end_off = {2'b00, addr[11:0]} + (({6'b000000, len} + 14'd1) << 2);
    return (addr[1:0] != 2'b00) || (end_off > 14'(PAGE_BYTES));
  endfunction

endpackage

// File: rtl/flash_axi_burst_master.sv
// AXI4 burst initiator for the EMC flash memory slave port.
// One command becomes exactly one INCR burst (read or write); only one
// transaction is ever outstanding.
// Ports:
//   s_axi_aclk / s_axi_areset : clock, asynchronous active-high reset
//   cmd_*                     : command handshake (write flag, address, len)
//   wr_*                      : write beat stream into the W channel
//   rd_*                      : read beat stream out of the R channel
//   done / err                : one-cycle completion pulse and its status
//   m_axi_mem_*               : AXI4 master port (AR, R, AW, W, B)
module flash_axi_burst_master
  import flash_axi_pkg::*;
#(
  parameter logic [3:0] ID_VAL = 4'h0
) (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  // command interface
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  // write beat stream
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        wr_valid,
  output logic        wr_ready,
  // read beat stream
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        rd_valid,
  input  logic        rd_ready,
  // status
  output logic        done,
  output logic        err,
  // AXI read address
  output logic [31:0] m_axi_mem_araddr,
  output logic [7:0]  m_axi_mem_arlen,
  output logic [2:0]  m_axi_mem_arsize,
  output logic [1:0]  m_axi_mem_arburst,
  output logic [3:0]  m_axi_mem_arid,
  output logic        m_axi_mem_arvalid,
  input  logic        m_axi_mem_arready,
  // AXI read data
  input  logic [31:0] m_axi_mem_rdata,
  input  logic [3:0]  m_axi_mem_rid,
  input  logic [1:0]  m_axi_mem_rresp,
  input  logic        m_axi_mem_rlast,
  input  logic        m_axi_mem_rvalid,
  output logic        m_axi_mem_rready,
  // AXI write address
  output logic [31:0] m_axi_mem_awaddr,
  output logic [7:0]  m_axi_mem_awlen,
  output logic [2:0]  m_axi_mem_awsize,
  output logic [1:0]  m_axi_mem_awburst,
  output logic [3:0]  m_axi_mem_awid,
  output logic        m_axi_mem_awvalid,
  input  logic        m_axi_mem_awready,
  // AXI write data
  output logic [31:0] m_axi_mem_wdata,
  output logic [3:0]  m_axi_mem_wstrb,
  output logic        m_axi_mem_wlast,
  output logic        m_axi_mem_wvalid,
  input  logic        m_axi_mem_wready,
  // AXI write response
  input  logic [3:0]  m_axi_mem_bid,
  input  logic [1:0]  m_axi_mem_bresp,
  input  logic        m_axi_mem_bvalid,
  output logic        m_axi_mem_bready
);

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [7:0]  len_reg;
  logic [7:0]  count_reg;
  logic        sticky_reg;
  logic        cmd_ready_reg;
  logic        arvalid_reg;
  logic        awvalid_reg;
  logic        bready_reg;
  logic        done_reg;
  logic        err_reg;

  logic in_r;
  logic in_w;
  logic r_fire;
  logic w_fire;
  logic at_last;
  logic r_beat_err;

  assign in_r    = (state_reg == ST_R);
  assign in_w    = (state_reg == ST_W);
  assign at_last = (count_reg == len_reg);
  assign r_fire  = in_r & m_axi_mem_rvalid & rd_ready;
  assign w_fire  = in_w & wr_valid & m_axi_mem_wready;

  // Per-beat read error: error response, foreign ID, or rlast that does
  // not line up with the latched length (early or late).
  assign r_beat_err = m_axi_mem_rresp[1] | (m_axi_mem_rid != ID_VAL) |
                      (m_axi_mem_rlast != at_last);

  // Constant AXI attributes
  assign m_axi_mem_arsize  = SIZE_4B;
  assign m_axi_mem_awsize  = SIZE_4B;
  assign m_axi_mem_arburst = BURST_INCR;
  assign m_axi_mem_awburst = BURST_INCR;
  assign m_axi_mem_arid    = ID_VAL;
  assign m_axi_mem_awid    = ID_VAL;

  assign m_axi_mem_araddr  = addr_reg;
  assign m_axi_mem_awaddr  = addr_reg;
  assign m_axi_mem_arlen   = len_reg;
  assign m_axi_mem_awlen   = len_reg;
  assign m_axi_mem_arvalid = arvalid_reg;
  assign m_axi_mem_awvalid = awvalid_reg;
  assign m_axi_mem_bready  = bready_reg;

  // R and W channels are pure pass-through, gated by state so that
  // nothing leaks onto either side outside its burst phase.
  assign rd_valid         = in_r & m_axi_mem_rvalid;
  assign rd_data          = in_r ? m_axi_mem_rdata : 32'h0;
  assign rd_last          = in_r & m_axi_mem_rlast;
  assign m_axi_mem_rready = in_r & rd_ready;

  assign m_axi_mem_wvalid = in_w & wr_valid;
  assign m_axi_mem_wdata  = in_w ? wr_data : 32'h0;
  assign m_axi_mem_wstrb  = in_w ? wr_strb : 4'h0;
  assign m_axi_mem_wlast  = in_w & at_last;
  assign wr_ready         = in_w & m_axi_mem_wready;

  assign cmd_ready = cmd_ready_reg;
  assign done      = done_reg;
  assign err       = err_reg;

  always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
    if (s_axi_areset) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= 32'h0;
      len_reg       <= 8'h0;
      count_reg     <= 8'h0;
      sticky_reg    <= 1'b0;
      cmd_ready_reg <= 1'b0;
      arvalid_reg   <= 1'b0;
      awvalid_reg   <= 1'b0;
      bready_reg    <= 1'b0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // cmd_ready rises on the first edge after reset and after RESP
          cmd_ready_reg <= 1'b1;
          if (cmd_valid && cmd_ready_reg) begin
            cmd_ready_reg <= 1'b0;
            addr_reg      <= cmd_addr;
            len_reg       <= cmd_len;
            count_reg     <= 8'h0;
            sticky_reg    <= 1'b0;
            if (cmd_is_bad(cmd_addr, cmd_len)) begin
              // no bus traffic; RESP raises done one cycle later
              sticky_reg <= 1'b1;
              state_reg  <= ST_RESP;
            end else if (cmd_write) begin
              awvalid_reg <= 1'b1;
              state_reg   <= ST_AW;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_AR;
            end
          end
        end

        ST_AR: begin
          if (m_axi_mem_arready) begin
            arvalid_reg <= 1'b0;
            state_reg   <= ST_R;
          end
        end

        ST_R: begin
          if (r_fire) begin
            count_reg <= count_reg + 8'd1;
            if (m_axi_mem_rlast) begin
              done_reg  <= 1'b1;
              err_reg   <= sticky_reg | r_beat_err;
              state_reg <= ST_RESP;
            end else begin
              sticky_reg <= sticky_reg | r_beat_err;
            end
          end
        end

        ST_AW: begin
          if (m_axi_mem_awready) begin
            awvalid_reg <= 1'b0;
            state_reg   <= ST_W;
          end
        end

        ST_W: begin
          if (w_fire) begin
            count_reg <= count_reg + 8'd1;
            if (at_last) begin
              bready_reg <= 1'b1;
              state_reg  <= ST_B;
            end
          end
        end

        ST_B: begin
          if (m_axi_mem_bvalid) begin
            bready_reg <= 1'b0;
            done_reg   <= 1'b1;
            err_reg    <= sticky_reg | m_axi_mem_bresp[1] |
                          (m_axi_mem_bid != ID_VAL);
            state_reg  <= ST_RESP;
          end
        end

        ST_RESP: begin
          // Arriving from R/B, done is already high: retire now.
          // Arriving from a rejected command, raise done first.
          if (!done_reg) begin
            done_reg <= 1'b1;
            err_reg  <= sticky_reg;
          end else begin
            done_reg      <= 1'b0;
            err_reg       <= 1'b0;
            cmd_ready_reg <= 1'b1;
            state_reg     <= ST_IDLE;
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_flash_axi_burst_master.sv
module tb_flash_axi_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_last, rd_valid, rd_ready;
  logic        done, err;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  arid, awid, rid, bid, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  flash_axi_burst_master dut (
    .s_axi_aclk(clk), .s_axi_areset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err),
    .m_axi_mem_araddr(araddr), .m_axi_mem_arlen(arlen), .m_axi_mem_arsize(arsize),
    .m_axi_mem_arburst(arburst), .m_axi_mem_arid(arid),
    .m_axi_mem_arvalid(arvalid), .m_axi_mem_arready(arready),
    .m_axi_mem_rdata(rdata), .m_axi_mem_rid(rid), .m_axi_mem_rresp(rresp),
    .m_axi_mem_rlast(rlast), .m_axi_mem_rvalid(rvalid), .m_axi_mem_rready(rready),
    .m_axi_mem_awaddr(awaddr), .m_axi_mem_awlen(awlen), .m_axi_mem_awsize(awsize),
    .m_axi_mem_awburst(awburst), .m_axi_mem_awid(awid),
    .m_axi_mem_awvalid(awvalid), .m_axi_mem_awready(awready),
    .m_axi_mem_wdata(wdata), .m_axi_mem_wstrb(wstrb), .m_axi_mem_wlast(wlast),
    .m_axi_mem_wvalid(wvalid), .m_axi_mem_wready(wready),
    .m_axi_mem_bid(bid), .m_axi_mem_bresp(bresp),
    .m_axi_mem_bvalid(bvalid), .m_axi_mem_bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: word aligned and the burst fits in its 4 KB page.
  function automatic bit model_bad(input int unsigned addr, input int unsigned len);
    return ((addr % 4) != 0) || (((addr % 4096) + 4 * (len + 1)) > 4096);
  endfunction

  // Presents a command, returns just after the negedge following accept.
  task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    #1;
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("cmd_ready_busy", 64'(cmd_ready), 64'd0);
  endtask

  task automatic finish_bad();
    chk("bad_no_done_yet", 64'(done), 64'd0);
    chk("bad_no_avalid", 64'({arvalid, awvalid}), 64'd0);
    @(negedge clk); #1;
    chk("bad_done", 64'(done), 64'd1);
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_no_avalid2", 64'({arvalid, awvalid}), 64'd0);
    @(negedge clk); #1;
    chk("bad_done_clear", 64'(done), 64'd0);
    chk("bad_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input bit stall,
                         input int bad_id_beat, input int bad_resp_beat,
                         input int rlast_beat, input bit fixed_data);
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    bit exp_err;
    bit hs;
    int cyc;
    int i;
    exp_err = model_bad(addr, len);
    send_cmd(1'b0, addr, len);
    if (exp_err) begin
      finish_bad();
      $display("READ  addr=0x%08h len=%0d rejected err=%0d", addr, len, err);
      return;
    end
    chk("arvalid", 64'(arvalid), 64'd1);
    chk("araddr", 64'(araddr), 64'(addr));
    chk("arlen", 64'(arlen), 64'(len));
    chk("arsize_burst_id", 64'({arsize, arburst, arid}), 64'({3'b010, 2'b01, 4'h0}));
    hs = 0; cyc = 0;
    while (!hs && cyc < 100) begin
      arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (arvalid !== 1'b1) chk("arvalid_hold", 64'(arvalid), 64'd1);
      hs = arvalid && arready;
      @(negedge clk);
      arready = 1'b0;
      cyc++;
    end
    if (!hs) begin chk("ar_timeout", 64'd0, 64'd1); return; end
    if (rlast_beat != int'(len)) exp_err = 1;
    if (bad_id_beat >= 0 && bad_id_beat <= rlast_beat) exp_err = 1;
    if (bad_resp_beat >= 0 && bad_resp_beat <= rlast_beat) exp_err = 1;
    for (int k = 0; k <= rlast_beat; k++)
      exp_q.push_back(fixed_data ? 32'hA0 + 32'(k) : $urandom);
    i = 0; cyc = 0;
    while (i <= rlast_beat && cyc < 3000) begin
      rvalid   = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      rdata    = exp_q[i];
      rid      = (i == bad_id_beat) ? 4'h1 : 4'h0;
      rresp    = (i == bad_resp_beat) ? 2'b10 : 2'b00;
      rlast    = (i == rlast_beat);
      rd_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (rvalid) begin
        chk("rd_valid", 64'(rd_valid), 64'd1);
        chk("rd_last", 64'(rd_last), 64'(i == rlast_beat));
        chk("rready", 64'(rready), 64'(rd_ready));
        if (rd_ready) begin
          got_q.push_back(rd_data);
          i++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    rvalid = 1'b0; rlast = 1'b0; rd_ready = 1'b0; rid = 4'h0; rresp = 2'b00;
    if (i <= rlast_beat) begin chk("r_timeout", 64'd0, 64'd1); return; end
    #1;
    chk("r_done", 64'(done), 64'd1);
    chk("r_err", 64'(err), 64'(exp_err));
    chk("r_beats", 64'(got_q.size()), 64'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk("rd_data", 64'(got_q[k]), 64'(exp_q[k]));
    $display("READ  addr=0x%08h len=%0d beats=%0d done=%0d err=%0d (exp %0d)",
             addr, len, got_q.size(), done, err, exp_err);
    @(negedge clk); #1;
    chk("r_done_pulse", 64'(done), 64'd0);
    chk("r_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input bit stall,
                          input logic [1:0] bresp_v, input logic [3:0] bid_v,
                          input int reset_at, input bit fixed_data);
    logic [31:0] wd[$];
    logic [3:0]  ws[$];
    bit exp_err;
    bit hs;
    int cyc;
    int i;
    exp_err = model_bad(addr, len) || bresp_v[1] || (bid_v != 4'h0);
    send_cmd(1'b1, addr, len);
    if (model_bad(addr, len)) begin
      finish_bad();
      $display("WRITE addr=0x%08h len=%0d rejected err=%0d", addr, len, err);
      return;
    end
    chk("awvalid", 64'(awvalid), 64'd1);
    chk("awaddr", 64'(awaddr), 64'(addr));
    chk("awlen", 64'(awlen), 64'(len));
    chk("awsize_burst_id", 64'({awsize, awburst, awid}), 64'({3'b010, 2'b01, 4'h0}));
    hs = 0; cyc = 0;
    while (!hs && cyc < 100) begin
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      hs = awvalid && awready;
      @(negedge clk);
      awready = 1'b0;
      cyc++;
    end
    if (!hs) begin chk("aw_timeout", 64'd0, 64'd1); return; end
    for (int k = 0; k <= int'(len); k++) begin
      wd.push_back(fixed_data ? 32'h11 * 32'(k + 1) : $urandom);
      ws.push_back(fixed_data ? 4'hF : 4'($urandom_range(0, 15)));
    end
    i = 0; cyc = 0;
    while (i <= int'(len) && cyc < 3000) begin
      wr_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      wr_data  = wd[i];
      wr_strb  = ws[i];
      wready   = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (wr_valid) begin
        chk("wvalid", 64'(wvalid), 64'd1);
        chk("wdata", 64'(wdata), 64'(wd[i]));
        chk("wstrb", 64'(wstrb), 64'(ws[i]));
        chk("wlast", 64'(wlast), 64'(i == int'(len)));
        if (wready) begin
          chk("wr_ready", 64'(wr_ready), 64'd1);
          i++;
        end
      end
      @(negedge clk);
      cyc++;
      if (reset_at >= 0 && i == reset_at) begin
        wr_valid = 1'b1; wready = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst_wvalid", 64'(wvalid), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_outputs", 64'({awvalid, bready, done, err, wlast}), 64'd0);
        $display("WRITE addr=0x%08h len=%0d reset after %0d beats", addr, len, i);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; wr_valid = 1'b0; wready = 1'b0;
        #1;
        chk("rst_release_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk); #1;
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        return;
      end
    end
    wr_valid = 1'b0; wready = 1'b0;
    if (i <= int'(len)) begin chk("w_timeout", 64'd0, 64'd1); return; end
    #1;
    chk("bready", 64'(bready), 64'd1);
    chk("w_idle_after_last", 64'(wvalid), 64'd0);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk); #1;
      if (bready !== 1'b1 || done !== 1'b0) chk("b_wait", 64'({bready, done}), 64'b10);
    end
    @(negedge clk);
    bvalid = 1'b1; bresp = bresp_v; bid = bid_v;
    @(negedge clk);
    bvalid = 1'b0; bresp = 2'b00; bid = 4'h0;
    #1;
    chk("w_done", 64'(done), 64'd1);
    chk("w_err", 64'(err), 64'(exp_err));
    chk("bready_drop", 64'(bready), 64'd0);
    $display("WRITE addr=0x%08h len=%0d bresp=%0d bid=%0d done=%0d err=%0d (exp %0d)",
             addr, len, bresp_v, bid_v, done, err, exp_err);
    @(negedge clk); #1;
    chk("w_done_pulse", 64'(done), 64'd0);
    chk("w_cmd_ready", 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  l;
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_data = 0; wr_strb = 0; wr_valid = 0; rd_ready = 0;
    arready = 0; rdata = 0; rid = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ctrl", 64'({cmd_ready, arvalid, awvalid, bready, done, err}), 64'd0);
    chk("reset_data", 64'({araddr, arlen}), 64'd0);
    chk("reset_wlast_rdlast", 64'({wlast, rd_last, wvalid, rd_valid}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

    // directed cases
    do_read(32'h100, 8'd3, 1'b0, -1, -1, 3, 1'b1);
    do_write(32'h200, 8'd1, 1'b0, 2'b00, 4'h0, -1, 1'b1);
    do_write(32'h300, 8'd2, 1'b0, 2'b10, 4'h0, -1, 1'b0);
    do_read(32'hFF8, 8'd3, 1'b0, -1, -1, 3, 1'b0);
    do_read(32'h400, 8'd7, 1'b1, 3, -1, 7, 1'b0);
    do_write(32'h500, 8'd3, 1'b0, 2'b00, 4'h0, 2, 1'b0);
    do_read(32'h600, 8'd4, 1'b0, -1, -1, 4, 1'b0);
    // boundary and error corners
    do_read(32'hC00, 8'd255, 1'b0, -1, -1, 255, 1'b0);
    do_read(32'hC04, 8'd255, 1'b0, -1, -1, 255, 1'b0);
    do_write(32'h702, 8'd0, 1'b0, 2'b00, 4'h0, -1, 1'b0);
    do_read(32'h800, 8'd5, 1'b0, -1, -1, 3, 1'b0);
    do_read(32'h900, 8'd3, 1'b1, -1, 2, 3, 1'b0);
    do_write(32'hA00, 8'd2, 1'b1, 2'b11, 4'h0, -1, 1'b0);
    do_write(32'hB00, 8'd1, 1'b0, 2'b00, 4'h3, -1, 1'b0);

    // randomized commands
    for (int n = 0; n < 12; n++) begin
      a = 32'h1000 * 32'($urandom_range(0, 3)) + 32'h4 * 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 7) == 0) a = a | 32'h1;
      l = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        do_write(a, l, 1'b1, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00, 4'h0, -1, 1'b0);
      else
        do_read(a, l, 1'b1, ($urandom_range(0, 3) == 0) ? int'(l) : -1, -1, int'(l), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flash_axi_burst_master.md
# flash_axi_burst_master

AXI4 burst initiator that drives the memory slave port of the AXI EMC flash wrapper (`s_axi_mem_*`). It turns single-word-stream commands into one INCR read or write burst each, collects R beats or feeds W beats, and reports completion and error status. It sits between the CPU-side flash controller logic and the EMC, and is the sole master on that port.

## Interface
- ID_VAL, 4'h0, constant driven on arid/awid; also the expected rid/bid.
- s_axi_aclk  in  1  clock.
- s_axi_areset  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  32  byte address; bits [1:0] must be 0.
- cmd_len  in  8  beats minus 1 (1..256 beats).
- wr_data / wr_strb  in  32 / 4  write beat payload.
- wr_valid / wr_ready  in / out  1 / 1  write-data stream handshake.
- rd_data  out  32  read beat payload.
- rd_last  out  1  marks the final read beat.
- rd_valid / rd_ready  out / in  1 / 1  read-data stream handshake.
- done  out  1  one-cycle pulse when a command retires.
- err  out  1  valid with done: SLVERR/DECERR, ID mismatch, misalignment or 4 KB crossing.
- m_axi_mem_araddr / arlen  out  32 / 8  read address and length.
- m_axi_mem_awaddr / awlen  out  32 / 8  write address and length.
- m_axi_mem_arsize, awsize  out  3  constant 3'b010.
- m_axi_mem_arburst, awburst  out  2  constant 2'b01 (INCR).
- m_axi_mem_arid, awid  out  4  ID_VAL.
- m_axi_mem_arvalid / arready, awvalid / awready  out / in  1 each.
- m_axi_mem_rdata / rid / rresp / rlast  in  32 / 4 / 2 / 1.
- m_axi_mem_rvalid / rready  in / out  1 / 1.
- m_axi_mem_wdata / wstrb / wlast  out  32 / 4 / 1.
- m_axi_mem_wvalid / wready  out / in  1 / 1.
- m_axi_mem_bid / bresp  in  4 / 2.
- m_axi_mem_bvalid / bready  in / out  1 / 1.
- The integrator ties cache/prot/lock to 4'b0011 / 3'b000 / 0 at the wrapper.

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On accept: bad command (cmd_addr[1:0]!=0, or addr[11:0] + 4·(len+1) > 4096) -> RESP with err=1 and no bus traffic; else cmd_write ? AW : AR. Address and length are latched.
  - AR: arvalid=1 until arready -> R.
  - R: rready = rd_ready, so R beats pass straight through (rd_valid=rvalid, rd_data=rdata, rd_last=rlast). A sticky error bit records rresp[1] or rid!=ID_VAL. The handshake with rlast -> RESP.
  - AW: awvalid=1 until awready -> W.
  - W: wvalid = wr_valid, wr_ready = wready. A beat counter counts up from 0; wlast=1 when count==len. The last handshake -> B.
  - B: bready=1. The bvalid handshake records bresp[1] or bid!=ID_VAL -> RESP.
  - RESP: done=1 and err=sticky for one cycle, then -> IDLE. The sticky bit clears at command accept.
- An rlast that arrives early or late versus the latched len sets err. The burst still ends on rlast.
- Outstanding transactions: exactly one; no AR/AW overlap.

## Timing
- Reset values: all valid/ready/done/err/wlast/rd_last outputs 0; addr/len/data outputs 0; FSM=IDLE. cmd_ready=1 from the first clock edge after reset release.
- Command accept to arvalid/awvalid: 1 cycle (registered).
- arvalid/awvalid/wvalid/wdata/wlast stay stable until their handshake completes.
- R path is combinational pass-through, so it adds no latency.
- Last R/B handshake to done: 1 cycle. done to next cmd_ready: 1 cycle.
- Reset asserted mid-burst: FSM returns to IDLE immediately and every output is deasserted. The EMC must be reset in the same domain.
- Simultaneous rvalid with rd_ready=0 holds the beat (backpressure); no buffering.

## Structure
- Package flash_axi_pkg holds: the FSM state enum; constants BURST_INCR=2'b01, SIZE_4B=3'b010, RESP_OKAY/EXOKAY/SLVERR/DECERR, PAGE_BYTES=4096.
- No sub-module required. The 4 KB/alignment checker may be a function in the package.

## Test plan
- Read cmd addr 0x100, len 3, slave returns 4 OKAY beats 0xA0..0xA3 -> arlen=3, rd_data sequence 0xA0..0xA3, rd_last on beat 4, done with err=0.
- Write addr 0x200, len 1, data 0x11/0x22, strb 0xF -> awlen=1, wlast on beat 2 only, done with err=0 after bvalid.
- Write with bresp=2'b10 -> done with err=1.
- Read addr 0xFF8, len 3 (crosses 4 KB) -> no arvalid, done with err=1 two cycles after accept.
- Read len 7 with random rready/rvalid stalls and rid=ID_VAL+1 on beat 3 -> all 8 beats delivered in order, err=1.
- Assert reset during the W state after 2 of 4 beats -> wvalid=0 and cmd_ready=0 in the same cycle; cmd_ready=1 after release; the next read completes cleanly.
